// File: rtl/bitpack_pkg.sv
// Shared definitions for the ML-DSA bit (un)packing blocks.
package bitpack_pkg;

    localparam int unsigned N_COEFF = 256;

    // Shared with the unpack FSM so both sides agree on state encoding.
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } pack_state_t;

    // Bits needed to hold a value in [0, b].
    function automatic int unsigned bitlen(input int unsigned b);
        return unsigned'($clog2(b + 1));
    endfunction

    // Output words per packed polynomial.
    function automatic int unsigned n_words(input int unsigned w, input int unsigned out_w);
        return (N_COEFF * w) / out_w;
    endfunction

endpackage

// File: rtl/simple_bit_pack.sv
// Streaming SimpleBitPack: 256 coefficients of W bits in, packed OUT_W-bit words out,
// LSB-first. Coefficients are gathered in a small accumulator and shifted out a word
// at a time.
module simple_bit_pack
    import bitpack_pkg::*;
#(
    parameter int unsigned B     = 1023,
    parameter int unsigned OUT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [bitlen(B)-1:0]  coeff,
    input  logic                  coeff_valid,
    output logic                  coeff_ready,
    output logic [OUT_W-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  done,
    output logic                  range_err
);

    localparam int unsigned W      = bitlen(B);
    localparam int unsigned NWORDS = n_words(W, OUT_W);
    localparam int unsigned AW     = OUT_W + W;
    localparam int unsigned FW     = $clog2(AW);
    localparam int unsigned WCW    = $clog2(NWORDS + 1);

    pack_state_t       state_q, state_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [FW-1:0]     fill_q, fill_d;
    logic [7:0]        ccnt_q, ccnt_d;
    logic [WCW-1:0]    wcnt_q, wcnt_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              done_q, done_d;
    logic              range_err_q, range_err_d;

    logic accept;
    logic word_move;
    logic final_hs;
    logic last_coeff;
    logic over_range;

    assign accept     = coeff_valid && coeff_ready;
    // Only ever true while fill >= OUT_W, so it can never coincide with an accept.
    assign word_move  = (fill_q >= FW'(OUT_W)) && (!out_valid_q || out_ready);
    assign final_hs   = (state_q == DRAIN) && out_valid_q && out_ready && out_last_q;
    assign last_coeff = (ccnt_q == 8'(N_COEFF - 1));
    // Widened by one bit so the compare stays meaningful when B fills all W bits.
    assign over_range = {1'b0, coeff} > (W + 1)'(B);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start is only honoured from IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (accept && last_coeff) state_d = DRAIN;
            DRAIN:   if (final_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM output: input side stalls only once a full word is waiting in the accumulator.
    always_comb begin
        coeff_ready = (state_q == RUN) && (fill_q < FW'(OUT_W));
    end

    // Accumulator, counters and output word next-state.
    always_comb begin
        acc_d       = acc_q;
        fill_d      = fill_q;
        ccnt_d      = ccnt_q;
        wcnt_d      = wcnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        range_err_d = range_err_q;
        done_d      = final_hs;

        if ((state_q == IDLE) && start) begin
            acc_d       = '0;
            fill_d      = '0;
            ccnt_d      = '0;
            wcnt_d      = '0;
            range_err_d = 1'b0;
        end else begin
            if (accept) begin
                // Bits above fill are always zero, so a plain overwrite is enough.
                acc_d[fill_q +: W] = coeff;
                fill_d             = fill_q + FW'(W);
                ccnt_d             = ccnt_q + 8'd1;
                if (over_range) begin
                    range_err_d = 1'b1;
                end
            end
            if (word_move) begin
                out_data_d  = acc_q[OUT_W-1:0];
                acc_d       = acc_q >> OUT_W;
                fill_d      = fill_q - FW'(OUT_W);
                out_valid_d = 1'b1;
                out_last_d  = (wcnt_q == WCW'(NWORDS - 1));
                wcnt_d      = wcnt_q + WCW'(1);
            end else if (out_ready) begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        end
    end

    // Datapath registers; reset discards any partially packed polynomial.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q       <= '0;
            fill_q      <= '0;
            ccnt_q      <= '0;
            wcnt_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            ccnt_q      <= ccnt_d;
            wcnt_q      <= wcnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            range_err_q <= range_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign range_err = range_err_q;

endmodule

// File: tb/tb_simple_bit_pack.sv
// Scoreboard bench for simple_bit_pack: a W=10 instance (a) and a W=3 instance (b).
module tb_simple_bit_pack;

    localparam int N_COEFF = 256;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, cv_a = 1'b0, ordy_a = 1'b1;
    logic [9:0]  coeff_a = '0;
    logic        cr_a, ov_a, ol_a, done_a, rerr_a;
    logic [31:0] od_a;

    logic        start_b = 1'b0, cv_b = 1'b0, ordy_b = 1'b1;
    logic [2:0]  coeff_b = '0;
    logic        cr_b, ov_b, ol_b, done_b, rerr_b;
    logic [31:0] od_b;

    simple_bit_pack #(.B(1023), .OUT_W(32)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .coeff(coeff_a), .coeff_valid(cv_a),
        .coeff_ready(cr_a), .out_data(od_a), .out_valid(ov_a), .out_ready(ordy_a),
        .out_last(ol_a), .done(done_a), .range_err(rerr_a)
    );

    simple_bit_pack #(.B(6), .OUT_W(32)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .coeff(coeff_b), .coeff_valid(cv_b),
        .coeff_ready(cr_b), .out_data(od_b), .out_valid(ov_b), .out_ready(ordy_b),
        .out_last(ol_b), .done(done_b), .range_err(rerr_b)
    );

    int nvec = 0;
    int nerr = 0;

    int unsigned coefs [N_COEFF];
    logic [32:0] q_a[$], q_b[$];   // {last, word}
    logic [31:0] rx_a[$], rx_b[$];
    int          ndone_a = 0, ndone_b = 0;
    bit          rnd_a = 0, rnd_b = 0, hold_a = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // out_ready drivers: random, held low for a stall window, or always ready.
    always @(posedge clk) begin
        #1;
        ordy_a = rnd_a ? 1'($urandom_range(0, 1)) : !hold_a;
        ordy_b = rnd_b ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor a: pop/compare on each output handshake, check hold under stall and done.
    bit          exp_done_a = 0, stall_a = 0;
    logic [32:0] prev_a = '0;
    always @(negedge clk) begin
        logic [32:0] e;
        if (!reset) begin
            stall_a    = 0;
            exp_done_a = 0;
        end else begin
            if (done_a || exp_done_a) check("done_a", 64'(done_a), 64'(exp_done_a));
            if (done_a) ndone_a++;
            exp_done_a = 0;
            if (stall_a) begin
                check("hold_valid_a", 64'(ov_a), 64'd1);
                check("hold_data_a", 64'({ol_a, od_a}), 64'(prev_a));
            end
            if (ov_a && ordy_a) begin
                if (q_a.size() == 0) begin
                    check("extra_word_a", 64'(q_a.size()), 64'd1);
                end else begin
                    e = q_a.pop_front();
                    check("word_a", 64'({ol_a, od_a}), 64'(e));
                    rx_a.push_back(od_a);
                    exp_done_a = e[32];
                end
            end
            stall_a = ov_a && !ordy_a;
            prev_a  = {ol_a, od_a};
        end
    end

    // Monitor b.
    bit exp_done_b = 0;
    always @(negedge clk) begin
        logic [32:0] e;
        if (!reset) begin
            exp_done_b = 0;
        end else begin
            if (done_b || exp_done_b) check("done_b", 64'(done_b), 64'(exp_done_b));
            if (done_b) ndone_b++;
            exp_done_b = 0;
            if (ov_b && ordy_b) begin
                if (q_b.size() == 0) begin
                    check("extra_word_b", 64'(q_b.size()), 64'd1);
                end else begin
                    e = q_b.pop_front();
                    check("word_b", 64'({ol_b, od_b}), 64'(e));
                    rx_b.push_back(od_b);
                    exp_done_b = e[32];
                end
            end
        end
    end

    // Reference packing: concatenate low W bits of each coefficient, cut into 32-bit words.
    task automatic push_model(input bit which);
        int w, nw;
        logic [2559:0] bs;
        logic [31:0]   word;
        w  = which ? 3 : 10;
        nw = N_COEFF * w / 32;
        bs = '0;
        for (int i = 0; i < N_COEFF; i++)
            for (int b = 0; b < w; b++) bs[i*w + b] = coefs[i][b];
        for (int k = 0; k < nw; k++) begin
            word = bs[k*32 +: 32];
            if (which) q_b.push_back({1'(k == nw - 1), word});
            else       q_a.push_back({1'(k == nw - 1), word});
        end
    endtask

    task automatic pulse_start(input bit which);
        if (which) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        @(negedge clk);
        check("ready_after_start", 64'(which ? cr_b : cr_a), 64'd1);
        check("rerr_clear_on_start", 64'(which ? rerr_b : rerr_a), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic feed(input bit which, input int n, input bit inject);
        bit got;
        int t;
        for (int i = 0; i < n; i++) begin
            if (which) begin
                coeff_b = coefs[i][2:0];
                cv_b    = 1'b1;
            end else begin
                coeff_a = coefs[i][9:0];
                cv_a    = 1'b1;
                if (inject && i == 50) start_a = 1'b1;  // must be ignored in RUN
            end
            got = 0;
            t   = 0;
            while (!got) begin
                @(negedge clk);
                got = which ? cr_b : cr_a;
                @(posedge clk); #1;
                start_a = 1'b0;
                t++;
                if (t > 100) begin
                    $display("FAIL feed_timeout: coeff %0d not accepted in %0d cycles, expected acceptance",
                             i, t);
                    nerr++;
                    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
                    $fatal(1, "input stalled");
                end
            end
        end
        cv_a = 1'b0;
        cv_b = 1'b0;
    endtask

    task automatic stall_out();
        repeat (60) @(posedge clk);
        #2 hold_a = 1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("bp_coeff_ready", 64'(cr_a), 64'd0);
        hold_a = 0;
    endtask

    task automatic wait_drain(input bit which);
        int t = 0;
        while (((which ? q_b.size() : q_a.size()) != 0) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        check("drain_words_left", 64'(which ? q_b.size() : q_a.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_poly(input bit which, input bit inject, input bit stall);
        int nw, d0;
        nw = N_COEFF * (which ? 3 : 10) / 32;
        if (which) rx_b.delete(); else rx_a.delete();
        d0 = which ? ndone_b : ndone_a;
        push_model(which);
        pulse_start(which);
        fork
            feed(which, N_COEFF, inject);
            if (stall) stall_out();
        join
        wait_drain(which);
        check("done_count", 64'(which ? ndone_b : ndone_a), 64'(d0 + 1));
        check("word_count", 64'(which ? rx_b.size() : rx_a.size()), 64'(nw));
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_out_valid"}, 64'(ov_a), 64'd0);
        check({tag, "_out_last"}, 64'(ol_a), 64'd0);
        check({tag, "_done"}, 64'(done_a), 64'd0);
        check({tag, "_coeff_ready"}, 64'(cr_a), 64'd0);
        check({tag, "_out_data"}, 64'(od_a), 64'd0);
        check({tag, "_range_err"}, 64'(rerr_a), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        nerr++;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w0;
        #2;
        check_idle_a("reset");
        check("reset_b_out_valid", 64'(ov_b), 64'd0);
        check("reset_b_coeff_ready", 64'(cr_b), 64'd0);
        #10;
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        // All-ones polynomial.
        for (int i = 0; i < N_COEFF; i++) coefs[i] = 1023;
        run_poly(0, 0, 0);
        check("ones_word0", 64'(rx_a[0]), 64'hFFFF_FFFF);
        check("ones_word79", 64'(rx_a[79]), 64'hFFFF_FFFF);

        // Ramp with a 20-cycle output stall and a stray start while running.
        for (int i = 0; i < N_COEFF; i++) coefs[i] = i % 1024;
        run_poly(0, 1, 1);
        check("ramp_word0", 64'(rx_a[0]), 64'hC020_0400);
        check("ramp_word1", 64'(rx_a[1]), 64'h6014_0400);
        check("ramp_range_err", 64'(rerr_a), 64'd0);

        // Single set bit, random output readiness.
        for (int i = 0; i < N_COEFF; i++) coefs[i] = 0;
        coefs[0] = 1;
        rnd_a = 1;
        run_poly(0, 0, 0);
        rnd_a = 0;
        check("one_word0", 64'(rx_a[0]), 64'h1);
        check("one_word79", 64'(rx_a[79]), 64'h0);

        // Asynchronous reset after 100 coefficients, then a clean polynomial.
        for (int i = 0; i < N_COEFF; i++) coefs[i] = $urandom_range(1, 1023);
        push_model(0);
        pulse_start(0);
        feed(0, 100, 0);
        #2 reset = 1'b0;
        #1 check_idle_a("midreset");
        q_a.delete();
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < N_COEFF; i++) coefs[i] = $urandom_range(0, 1023);
        run_poly(0, 0, 0);

        // W=3: out-of-range coefficient is flagged and packed as its low bits.
        rnd_b = 1;
        for (int i = 0; i < N_COEFF; i++) coefs[i] = $urandom_range(0, 6);
        coefs[5] = 7;
        run_poly(1, 0, 0);
        check("b_range_err_set", 64'(rerr_b), 64'd1);
        w0 = rx_b[0];
        check("b_word0_bits17_15", 64'(w0[17:15]), 64'd7);
        repeat (5) @(posedge clk);
        #1 check("b_range_err_sticky", 64'(rerr_b), 64'd1);

        for (int i = 0; i < N_COEFF; i++) coefs[i] = i % 7;
        run_poly(1, 0, 0);
        check("b_range_err_clean", 64'(rerr_b), 64'd0);
        rnd_b = 0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
